imm_gen_pipe: RTL and testbench

//  Pipelined RV32I/RV64I immediate generator for the decode stage. Takes one 32-bit instruction per

---
 rtl/imm_gen_pipe_pkg.sv | 42 ++++
 rtl/imm_gen_pipe_decode.sv | 36 +++
 rtl/imm_gen_pipe.sv | 98 +++++++++
 tb/tb_imm_gen_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: opcodes,
// format codes and the opcode-to-format classifier.
package imm_gen_pipe_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // Every supported opcode ends in 2'b11, so anything else lands in FMT_ILL.
    function automatic fmt_e decode_fmt(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: decode_fmt = FMT_I;
            OP_STORE:                           decode_fmt = FMT_S;
            OP_BRANCH:                          decode_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                   decode_fmt = FMT_U;
            OP_JAL:                             decode_fmt = FMT_J;
            OP_REG, OP_REG32:                   decode_fmt = FMT_R;
            default:                            decode_fmt = FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational decode: raw instruction -> sign-extended immediate,
// format code and illegal flag.
module imm_gen_pipe_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    fmt_e        f;
    logic [31:0] imm32;

    // All formats take their sign from instr[31]; build a 32-bit value, then widen.
    always_comb begin
        f     = decode_fmt(instr[6:0]);
        imm32 = '0;
        case (f)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        fmt     = f;
        illegal = (f == FMT_ILL);
        imm     = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on the input side, then a
// one-entry skid buffer feeding the output register, plus a saturating
// count of accepted illegal instructions.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ill_count,
    input  logic             ill_clr
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    logic             in_fire;

    imm_gen_pipe_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    // Ready comes only from the registered skid state, never from out_ready.
    assign in_ready = !skid_valid && !reset;
    assign in_fire  = in_valid && in_ready;

    // Output register refills from the skid first so beat order is preserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            imm        <= '0;
            fmt        <= '0;
            illegal    <= 1'b0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= '0;
            skid_ill   <= 1'b0;
            skid_tag   <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                imm        <= skid_imm;
                fmt        <= skid_fmt;
                illegal    <= skid_ill;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid  <= 1'b1;
                imm        <= dec_imm;
                fmt        <= dec_fmt;
                illegal    <= dec_ill;
                out_tag    <= in_tag;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
            skid_tag   <= in_tag;
        end
    end

    // Saturating illegal counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || ill_clr) begin
            ill_count <= '0;
        end else if (in_fire && dec_ill && (ill_count != {CNT_W{1'b1}})) begin
            ill_count <= ill_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three builds (XLEN=64/CNT_W=16, CNT_W=2, XLEN=32)
// share one stimulus stream and are checked against a queue-based model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        ill_clr;
    logic [31:0] instr;
    logic [7:0]  in_tag;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [63:0] a_imm;
    logic [2:0]  a_fmt;
    logic [7:0]  a_out_tag;
    logic [15:0] a_ill_count;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [7:0]  b_out_tag;
    logic [1:0]  b_ill_count;

    logic        c_in_ready, c_out_valid, c_illegal;
    logic [31:0] c_imm;
    logic [2:0]  c_fmt;
    logic [7:0]  c_out_tag;
    logic [15:0] c_ill_count;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
        .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal), .out_tag(a_out_tag),
        .ill_count(a_ill_count), .ill_clr(ill_clr));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
        .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal), .out_tag(b_out_tag),
        .ill_count(b_ill_count), .ill_clr(ill_clr));

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .instr(instr), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
        .imm(c_imm), .fmt(c_fmt), .illegal(c_illegal), .out_tag(c_out_tag),
        .ill_count(c_ill_count), .ill_clr(ill_clr));

    typedef struct {
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cnt_a    = 0;
    int   cnt_b    = 0;
    bit   fired;
    int   next_beat;
    logic [7:0] tag_ctr;
    logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h12, 7'h0F, 7'h73};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Interpret the low 'bits' bits of v as a two's-complement number.
    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [7:0] t);
        exp_t   e;
        longint u;
        longint f;
        u     = longint'(w);
        e.tag = t;
        e.imm = 64'd0;
        e.ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: begin
                e.fmt = 3'd1;
                e.imm = sx((u >> 20) & 'hFFF, 12);
            end
            7'h23: begin
                e.fmt = 3'd2;
                f = ((u >> 25) & 'h7F) * 32 + ((u >> 7) & 'h1F);
                e.imm = sx(f, 12);
            end
            7'h63: begin
                e.fmt = 3'd3;
                f = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                  + ((u >> 25) & 'h3F) * 32 + ((u >> 8) & 'hF) * 2;
                e.imm = sx(f, 13);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = sx((u >> 12) * 4096, 32);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                f = ((u >> 31) & 1) * (1 << 20) + ((u >> 12) & 'hFF) * (1 << 12)
                  + ((u >> 20) & 1) * (1 << 11) + ((u >> 21) & 'h3FF) * 2;
                e.imm = sx(f, 21);
            end
            7'h33, 7'h3B: e.fmt = 3'd0;
            default: begin
                e.fmt = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // One clock: check outputs against the model, advance the model, clock, check counters.
    task automatic cycle(output bit f);
        exp_t e;
        bit   fin, fout;
        if (reset) begin
            chk("in_ready_in_reset", 64'(a_in_ready), 64'd0);
        end else begin
            chk("in_ready", 64'(a_in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(a_out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_tag", 64'(a_out_tag), 64'(q[0].tag));
                chk("imm", a_imm, q[0].imm);
                chk("fmt", 64'(a_fmt), 64'(q[0].fmt));
                chk("illegal", 64'(a_illegal), 64'(q[0].ill));
                chk("imm_x32", 64'(c_imm), 64'(q[0].imm[31:0]));
            end
        end
        fin  = !reset && in_valid && (q.size() < 2);
        fout = !reset && out_ready && (q.size() != 0);
        e    = ref_decode(instr, in_tag);
        if (reset) begin
            q.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (fout) void'(q.pop_front());
            if (fin) q.push_back(e);
            if (ill_clr) begin
                cnt_a = 0;
                cnt_b = 0;
            end else if (fin && e.ill) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_b < 3) cnt_b++;
            end
        end
        f = fin;
        @(posedge clk);
        @(negedge clk);
        chk("ill_count", 64'(a_ill_count), 64'(cnt_a));
        chk("ill_count_w2", 64'(b_ill_count), 64'(cnt_b));
    endtask

    task automatic send(input logic [31:0] w, input logic [7:0] t);
        bit f;
        instr    = w;
        in_tag   = t;
        in_valid = 1'b1;
        cycle(f);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle(f);
        chk("drained", 64'(a_out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ill_clr = 1'b0;
        instr = 32'h0; in_tag = 8'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_imm", a_imm, 64'd0);
        chk("rst_fmt", 64'(a_fmt), 64'd0);
        chk("rst_illegal", 64'(a_illegal), 64'd0);
        chk("rst_out_tag", 64'(a_out_tag), 64'd0);
        chk("rst_ill_count", 64'(a_ill_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(a_in_ready), 64'd1);

        // Directed decode beats with known results.
        send(32'hF8008113, 8'd1);
        chk("addi_fmt", 64'(a_fmt), 64'd1);
        chk("addi_imm", a_imm, 64'hFFFF_FFFF_FFFF_FF80);
        send(32'hFE50A9A3, 8'd2);
        chk("sw_fmt", 64'(a_fmt), 64'd2);
        chk("sw_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFF3);
        send(32'h800000B7, 8'd3);
        chk("lui_fmt", 64'(a_fmt), 64'd4);
        chk("lui_imm", a_imm, 64'hFFFF_FFFF_8000_0000);
        send(32'hFFDFF06F, 8'd4);
        chk("jal_fmt", 64'(a_fmt), 64'd5);
        chk("jal_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        send(32'hFFF00093, 8'd5);
        chk("x32_addi_m1", 64'(c_imm), 64'hFFFF_FFFF);
        send(32'h002081B3, 8'd6);
        chk("x32_add_fmt", 64'(c_fmt), 64'd0);
        chk("x32_add_imm", 64'(c_imm), 64'd0);
        send(32'h0000007F, 8'd7);
        chk("ill_flag", 64'(a_illegal), 64'd1);
        chk("ill_fmt", 64'(a_fmt), 64'd7);
        chk("ill_imm", a_imm, 64'd0);
        send(32'h00000013, 8'd8);
        chk("ill_count_one", 64'(a_ill_count), 64'd1);
        drain();

        // Back-to-back stream with a 3-cycle consumer stall.
        next_beat = 0;
        for (int c = 0; c < 30 && next_beat < 4; c++) begin
            in_valid  = 1'b1;
            in_tag    = 8'(next_beat + 1);
            instr     = {$urandom_range(0, 32'h01FF_FFFF), 7'h13};
            out_ready = !(c >= 2 && c < 5);
            cycle(fired);
            if (fired) next_beat++;
        end
        drain();

        // Counter saturation on the narrow build, then clear versus increment.
        ill_clr = 1'b1;
        cycle(fired);
        ill_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0000007F, 8'(8'h40 + i));
        chk("sat_w2", 64'(b_ill_count), 64'd3);
        chk("count_w16_five", 64'(a_ill_count), 64'd5);
        ill_clr = 1'b1;
        send(32'h0000007F, 8'h50);
        ill_clr = 1'b0;
        chk("clr_wins", 64'(a_ill_count), 64'd0);
        chk("clr_wins_w2", 64'(b_ill_count), 64'd0);
        drain();

        // Fill output register and skid, then reset.
        out_ready = 1'b0;
        send(32'h0000007F, 8'h61);
        send(32'h0000007F, 8'h62);
        in_valid = 1'b1;
        instr    = 32'h00100093;
        in_tag   = 8'h63;
        cycle(fired);
        in_valid = 1'b0;
        reset    = 1'b1;
        cycle(fired);
        chk("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_mid_ill_count", 64'(a_ill_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;

        // Randomized traffic with random backpressure and occasional clears.
        tag_ctr = 8'h80;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ill_clr   = ($urandom_range(0, 31) == 0);
            instr     = {$urandom_range(0, 32'h01FF_FFFF), ops[$urandom_range(0, 15)]};
            in_tag    = tag_ctr;
            cycle(fired);
            if (fired) tag_ctr = tag_ctr + 8'd1;
        end
        ill_clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
